seq1011_frame_ctrl: RTL and testbench

- Sequences parallel words from an upstream producer into a serial bitstream (MSB first, one bit per cycle).
- Runs an overlapping Moore-style detector for a 4-bit pattern (default 1011) on that stream.
- Returns a per-word detection summary over a valid/ready result handshake.
- Sits between a word-oriented host interface and the serial sequence-detection datapath; owns word acceptance, serialization timing, detector history and result reporting.

---
 rtl/seq1011_frame_ctrl.sv | 107 ++++++++++
 tb/tb_seq1011_frame_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq1011_frame_ctrl.sv
// Word-to-serial sequencer with an overlapping Moore 4-bit pattern detector and per-word result handshake.
// Optional: define SEQ1011_CARRY_HISTORY_EN to keep detector history across word boundaries.
module seq1011_frame_ctrl #(
  parameter int          DATA_W  = 16,
  parameter int          CNT_W   = 5,
  parameter logic [3:0]  PATTERN = 4'b1011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_len,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              det_pulse,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [CNT_W-1:0]  out_first,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] word;
  logic [CNT_W-1:0]  len, idx, count, first, len_c;
  logic [2:0]        hist;
  logic [1:0]        hv;
  logic              b, last, match;

  // Zero or oversize lengths fall back to the full word.
  assign len_c = (in_len == '0 || in_len > CNT_W'(DATA_W)) ? CNT_W'(DATA_W) : in_len;
  // The word register shifts left, so the next bit is always its MSB.
  assign b     = word[DATA_W-1];
  assign last  = (idx == len - CNT_W'(1));
  assign match = (hv == 2'd3) && ({hist, b} == PATTERN);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == REPORT);
  assign busy      = (state != IDLE);
  assign out_count = count;
  assign out_first = first;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = SHIFT;
      SHIFT:   if (last)      state_nx = REPORT;
      REPORT:  if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word      <= '0;
      len       <= '0;
      idx       <= '0;
      count     <= '0;
      first     <= '1;
      hist      <= '0;
      hv        <= '0;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      det_pulse <= 1'b0;
    end else begin
      ser_valid <= 1'b0;
      det_pulse <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          word  <= in_data;
          len   <= len_c;
          idx   <= '0;
          count <= '0;
          first <= '1;
`ifdef SEQ1011_CARRY_HISTORY_EN
`else
          hist  <= '0;
          hv    <= '0;
`endif
        end
        SHIFT: begin
          word      <= word << 1;
          idx       <= idx + CNT_W'(1);
          ser_bit   <= b;
          ser_valid <= 1'b1;
          det_pulse <= match;
          hist      <= {hist[1:0], b};
          if (hv != 2'd3) hv <= hv + 2'd1;
          if (match) begin
            count <= count + CNT_W'(1);
            if (count == '0) first <= idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq1011_frame_ctrl.sv
// Self-checking bench for seq1011_frame_ctrl: vector table, corner sequences, and random words vs a bitstream model.
module tb_seq1011_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [15:0] in_data;
  logic [4:0]  in_len;
  logic        in_ready, ser_bit, ser_valid, det_pulse, out_valid, busy;
  logic [4:0]  out_count, out_first;

  int checks = 0;
  int errors = 0;
  bit stream[$];  // last (up to 4) bits seen by the detector model

  seq1011_frame_ctrl #(.DATA_W(16), .CNT_W(5), .PATTERN(4'b1011)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .ser_bit(ser_bit), .ser_valid(ser_valid),
    .det_pulse(det_pulse), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_first(out_first), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    stream.delete();
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready",  32'(in_ready), 1);
    chk("rst_ser_bit",   32'(ser_bit), 0);
    chk("rst_ser_valid", 32'(ser_valid), 0);
    chk("rst_det_pulse", 32'(det_pulse), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_out_first", 32'(out_first), 32'h1F);
  endtask

  // Offers one word at a negedge, checks every serialized bit against the model,
  // holds the result for `hold` cycles of backpressure, then completes the handshake.
  task automatic send_word(input logic [15:0] d, input logic [4:0] ln, input int hold,
                           output int cnt, output int first);
    int L, ecnt, efirst;
    bit b, m;
    bit [3:0] w;
    L = (ln == 0 || ln > 16) ? 16 : int'(ln);
    ecnt = 0;
    efirst = 31;
`ifndef SEQ1011_CARRY_HISTORY_EN
    stream.delete();
`endif
    chk("idle_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_data = d; in_len = ln; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_data = 16'($urandom); in_len = 5'($urandom);
    chk("shift_in_ready", 32'(in_ready), 0);
    chk("shift_busy", 32'(busy), 1);
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      b = d[15-k];
      stream.push_back(b);
      if (stream.size() > 4) void'(stream.pop_front());
      m = 1'b0;
      if (stream.size() == 4) begin
        w = {stream[0], stream[1], stream[2], stream[3]};
        m = (w == 4'b1011);
      end
      if (m) begin
        if (ecnt == 0) efirst = k;
        ecnt++;
      end
      chk("ser_valid", 32'(ser_valid), 1);
      chk("ser_bit",   32'(ser_bit), 32'(b));
      chk("det_pulse", 32'(det_pulse), 32'(m));
      chk("out_valid_timing", 32'(out_valid), (k == L-1) ? 1 : 0);
    end
    chk("out_count", 32'(out_count), ecnt);
    chk("out_first", 32'(out_first), efirst);
    for (int h = 0; h < hold; h++) begin
      in_valid = (h == 0);
      in_data = 16'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_ser_valid", 32'(ser_valid), 0);
      chk("hold_in_ready",  32'(in_ready), 0);
      chk("hold_out_count", 32'(out_count), ecnt);
      chk("hold_out_first", 32'(out_first), efirst);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("done_out_valid", 32'(out_valid), 0);
    chk("done_in_ready",  32'(in_ready), 1);
    chk("done_busy",      32'(busy), 0);
    cnt = ecnt;
    first = efirst;
  endtask

  typedef struct {
    logic [15:0] d;
    logic [4:0]  ln;
    int          hold;
    int          ecnt;
    int          efirst;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int c, f;
    tbl[0] = '{16'hB000, 5'd4,  0,  1, 3};
    tbl[1] = '{16'hB600, 5'd7,  0,  2, 3};
    tbl[2] = '{16'h0000, 5'd0,  0,  0, 31};
    tbl[3] = '{16'hB000, 5'd4,  10, 1, 3};
    tbl[4] = '{16'hB6B6, 5'd20, 1,  4, 3};

    in_data = '0; in_len = '0;
    do_reset();
    chk_reset_vals();

    for (int i = 0; i < 5; i++) begin
      do_reset();
      send_word(tbl[i].d, tbl[i].ln, tbl[i].hold, c, f);
      chk($sformatf("tbl%0d_count", i), c, tbl[i].ecnt);
      chk($sformatf("tbl%0d_first", i), f, tbl[i].efirst);
    end

    // Reset partway through a word: nothing of it may survive.
    do_reset();
    in_valid = 1'b1; in_data = 16'hFFFF; in_len = 5'd0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("midop_ser_valid", 32'(ser_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    stream.delete();
    send_word(16'hB000, 5'd4, 0, c, f);
    chk("after_rst_count", c, 1);

    // Pattern spanning a word boundary.
    do_reset();
    send_word(16'h0005, 5'd16, 0, c, f);
    chk("bnd_w1_count", c, 0);
    send_word(16'h8000, 5'd1, 0, c, f);
`ifdef SEQ1011_CARRY_HISTORY_EN
    chk("bnd_w2_count", c, 1);
    chk("bnd_w2_first", f, 0);
`else
    chk("bnd_w2_count", c, 0);
    chk("bnd_w2_first", f, 31);
`endif

    // Random words, biased toward pattern-rich data.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      logic [15:0] d;
      d = (i % 3 == 0) ? 16'($urandom) : {4'($urandom) | 4'b1011, 12'($urandom)} ^ 16'($urandom_range(0, 7));
      send_word(d, 5'($urandom), int'($urandom_range(0, 3)), c, f);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
